// File: rtl/axi4_accel_pkg.sv
// -----------------------------------------------------------------------------
// axi4_accel_pkg
//   Shared definitions for the accelerator register bank: AXI response codes,
//   register byte offsets, CTRL/STATUS bit positions, the register decode type
//   and two small helpers (address decode, byte-strobe merge).
// -----------------------------------------------------------------------------
package axi4_accel_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte offsets inside the 256-byte window
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_KEY    = 8'h40;
  localparam logic [7:0] OFF_DIN    = 8'h80;
  localparam logic [7:0] OFF_DOUT   = 8'hC0;

  // CTRL bits
  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE     = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_CLR_DONE = 3;

  // STATUS bits
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERROR = 2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_STATUS,
    REG_KEY,
    REG_DIN,
    REG_DOUT
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [3:0] idx;   // word index inside KEY/DIN/DOUT
  } reg_dec_t;

  // waddr is the byte address with its two LSBs dropped; base_hi is the
  // window base bits [31:8]. Array regions are 16 words wide, but only the
  // configured number of words is mapped; the rest decode as REG_NONE.
  function automatic reg_dec_t decode_addr(input logic [29:0] waddr,
                                           input logic [23:0] base_hi,
                                           input int          key_words,
                                           input int          data_words);
    reg_dec_t   d;
    logic [7:0] off;
    logic [7:0] region;
    off    = {waddr[5:0], 2'b00};
    region = {waddr[5:4], 6'd0};
    d.sel  = REG_NONE;
    d.idx  = waddr[3:0];
    if (waddr[29:6] == base_hi) begin
      if (off == OFF_CTRL)
        d.sel = REG_CTRL;
      else if (off == OFF_STATUS)
        d.sel = REG_STATUS;
      else if (region == OFF_KEY && int'(waddr[3:0]) < key_words)
        d.sel = REG_KEY;
      else if (region == OFF_DIN && int'(waddr[3:0]) < data_words)
        d.sel = REG_DIN;
      else if (region == OFF_DOUT && int'(waddr[3:0]) < data_words)
        d.sel = REG_DOUT;
    end
    return d;
  endfunction

  // Per-byte merge of new write data into an existing register value.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/axi4_lite_wr_join.sv
// -----------------------------------------------------------------------------
// axi4_lite_wr_join
//   Joins the independent AXI4-lite AW and W channels. Each channel has a
//   one-deep holding register; its ready is high while that register is
//   empty. Once both are held, wr_commit strobes for one cycle with the held
//   address/data/strobe; the response supplied by the register file in that
//   cycle is captured and presented on B. The holding registers stay full
//   (blocking further AW/W) until the B handshake completes.
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   mem_axi_aw*/w*/b*                   AXI4-lite write channels
//   wr_commit                           one-cycle commit strobe
//   wr_addr/wr_data/wr_strb             held write transaction
//   wr_resp                             response for the committing write
// -----------------------------------------------------------------------------
module axi4_lite_wr_join (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  output logic [1:0]  mem_axi_bresp,
  output logic        wr_commit,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  input  logic [1:0]  wr_resp
);
  import axi4_accel_pkg::*;

  logic live;     // low during reset so both readies read 0
  logic aw_full;
  logic w_full;

  assign mem_axi_awready = live & ~aw_full;
  assign mem_axi_wready  = live & ~w_full;
  assign wr_commit       = aw_full & w_full & ~mem_axi_bvalid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      live           <= 1'b0;
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      wr_strb        <= '0;
      mem_axi_bvalid <= 1'b0;
      mem_axi_bresp  <= RESP_OKAY;
    end else begin
      live <= 1'b1;
      if (mem_axi_awvalid && mem_axi_awready) begin
        aw_full <= 1'b1;
        wr_addr <= mem_axi_awaddr;
      end
      if (mem_axi_wvalid && mem_axi_wready) begin
        w_full  <= 1'b1;
        wr_data <= mem_axi_wdata;
        wr_strb <= mem_axi_wstrb;
      end
      if (wr_commit) begin
        mem_axi_bvalid <= 1'b1;
        mem_axi_bresp  <= wr_resp;
      end
      if (mem_axi_bvalid && mem_axi_bready) begin
        mem_axi_bvalid <= 1'b0;
        aw_full        <= 1'b0;
        w_full         <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_accel_regbank.sv
// -----------------------------------------------------------------------------
// axi4_accel_regbank
//   AXI4-lite slave exposing one accelerator core as a 256-byte register bank:
//   CTRL (start/mode/irq enable/clear done), STATUS (busy/done/error),
//   KEY[KEY_WORDS], DIN[DATA_WORDS] and DOUT[DATA_WORDS]. Provides BRESP/RRESP,
//   byte strobes, a start/busy/done handshake and a registered interrupt.
// Parameters
//   BASE_ADDR   window base, 256-byte aligned
//   KEY_WORDS   number of 32-bit key registers (1..16)
//   DATA_WORDS  number of 32-bit DIN and DOUT registers (1..16)
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   mem_axi_*            AXI4-lite slave (AW, W, B, AR, R)
//   core_start           one-cycle start pulse
//   core_mode            CTRL.MODE
//   core_key, core_din   packed registers, word 0 in the MSBs
//   core_done            one-cycle completion pulse, qualifies dout/error
//   core_dout            result, word 0 in the MSBs
//   core_error           error flag from the core
//   irq                  registered STATUS.DONE & CTRL.IRQ_EN
// -----------------------------------------------------------------------------
module axi4_accel_regbank #(
  parameter logic [31:0] BASE_ADDR  = 32'h2500_0000,
  parameter int          KEY_WORDS  = 8,
  parameter int          DATA_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_axi_awvalid,
  output logic                    mem_axi_awready,
  input  logic [31:0]             mem_axi_awaddr,
  input  logic                    mem_axi_wvalid,
  output logic                    mem_axi_wready,
  input  logic [31:0]             mem_axi_wdata,
  input  logic [3:0]              mem_axi_wstrb,
  output logic                    mem_axi_bvalid,
  input  logic                    mem_axi_bready,
  output logic [1:0]              mem_axi_bresp,
  input  logic                    mem_axi_arvalid,
  output logic                    mem_axi_arready,
  input  logic [31:0]             mem_axi_araddr,
  output logic                    mem_axi_rvalid,
  input  logic                    mem_axi_rready,
  output logic [31:0]             mem_axi_rdata,
  output logic [1:0]              mem_axi_rresp,
  output logic                    core_start,
  output logic                    core_mode,
  output logic [32*KEY_WORDS-1:0] core_key,
  output logic [32*DATA_WORDS-1:0] core_din,
  input  logic                    core_done,
  input  logic [32*DATA_WORDS-1:0] core_dout,
  input  logic                    core_error,
  output logic                    irq
);
  import axi4_accel_pkg::*;

  localparam logic [23:0] BASE_HI = BASE_ADDR[31:8];

  // Register file
  logic        busy, done, error, irq_en;
  logic [31:0] key_q  [KEY_WORDS];
  logic [31:0] din_q  [DATA_WORDS];
  logic [31:0] dout_q [DATA_WORDS];

  // ---------------------------------------------------------------------------
  // Write channel join
  // ---------------------------------------------------------------------------
  logic        wr_commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  wr_resp;

  axi4_lite_wr_join u_wr_join (
    .clk             (clk),
    .reset           (reset),
    .mem_axi_awvalid (mem_axi_awvalid),
    .mem_axi_awready (mem_axi_awready),
    .mem_axi_awaddr  (mem_axi_awaddr),
    .mem_axi_wvalid  (mem_axi_wvalid),
    .mem_axi_wready  (mem_axi_wready),
    .mem_axi_wdata   (mem_axi_wdata),
    .mem_axi_wstrb   (mem_axi_wstrb),
    .mem_axi_bvalid  (mem_axi_bvalid),
    .mem_axi_bready  (mem_axi_bready),
    .mem_axi_bresp   (mem_axi_bresp),
    .wr_commit       (wr_commit),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_strb         (wr_strb),
    .wr_resp         (wr_resp)
  );

  // Byte-address LSBs are ignored by the decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{wr_addr[1:0], mem_axi_araddr[1:0]};

  // ---------------------------------------------------------------------------
  // Write decode and response
  // ---------------------------------------------------------------------------
  reg_dec_t wdec;
  logic     wr_ok;

  assign wdec = decode_addr(wr_addr[31:2], BASE_HI, KEY_WORDS, DATA_WORDS);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_resp = RESP_OKAY;
    wr_ok   = 1'b0;
    case (wdec.sel)
      REG_CTRL: begin
        // While busy only IRQ_EN and CLR_DONE may change; a START or a MODE
        // change is rejected and the whole write is dropped.
        if (busy && wr_strb[0] &&
            (wr_data[CTRL_START] || (wr_data[CTRL_MODE] != core_mode)))
          wr_resp = RESP_SLVERR;
        else
          wr_ok = 1'b1;
      end
      REG_KEY, REG_DIN: begin
        if (busy) wr_resp = RESP_SLVERR;
        else      wr_ok   = 1'b1;
      end
      REG_STATUS, REG_DOUT: wr_resp = RESP_SLVERR;
      default:              wr_resp = RESP_DECERR;
    endcase
  end

  logic wr_en, ctrl_wr, start_req, clr_req, done_evt;

  assign wr_en     = wr_commit & wr_ok;
  assign ctrl_wr   = wr_en && (wdec.sel == REG_CTRL) && wr_strb[0];
  assign start_req = ctrl_wr & wr_data[CTRL_START];
  assign clr_req   = ctrl_wr & wr_data[CTRL_CLR_DONE];
  assign done_evt  = core_done & busy;

  // ---------------------------------------------------------------------------
  // Register file, start/busy/done, interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      irq_en     <= 1'b0;
      core_mode  <= 1'b0;
      core_start <= 1'b0;
      irq        <= 1'b0;
      // NOTE: the KEY/DIN/DOUT arrays are small flop banks, not RAM, so they
      // are cleared on reset along with the control state.
      for (int i = 0; i < KEY_WORDS; i++)  key_q[i]  <= '0;
      for (int i = 0; i < DATA_WORDS; i++) din_q[i]  <= '0;
      for (int i = 0; i < DATA_WORDS; i++) dout_q[i] <= '0;
    end else begin
      core_start <= start_req;

      if (ctrl_wr) begin
        core_mode <= wr_data[CTRL_MODE];
        irq_en    <= wr_data[CTRL_IRQ_EN];
      end

      if (wr_en && wdec.sel == REG_KEY)
        for (int i = 0; i < KEY_WORDS; i++)
          if (wdec.idx == 4'(i)) key_q[i] <= apply_strb(key_q[i], wr_data, wr_strb);

      if (wr_en && wdec.sel == REG_DIN)
        for (int i = 0; i < DATA_WORDS; i++)
          if (wdec.idx == 4'(i)) din_q[i] <= apply_strb(din_q[i], wr_data, wr_strb);

      // start needs !busy and done needs busy, so they never coincide; a
      // completion beats a same-cycle CLR_DONE.
      if (start_req) begin
        busy  <= 1'b1;
        done  <= 1'b0;
        error <= 1'b0;
      end else if (done_evt) begin
        busy  <= 1'b0;
        done  <= 1'b1;
        error <= core_error;
        for (int i = 0; i < DATA_WORDS; i++)
          dout_q[i] <= core_dout[32*(DATA_WORDS-i)-1 -: 32];
      end else if (clr_req) begin
        done <= 1'b0;
      end

      irq <= done & irq_en;
    end
  end

  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign core_key[32*(KEY_WORDS-g)-1 -: 32] = key_q[g];
  end

  for (genvar g = 0; g < DATA_WORDS; g++) begin : g_din
    assign core_din[32*(DATA_WORDS-g)-1 -: 32] = din_q[g];
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  reg_dec_t    rdec;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rd_live;   // holds arready low during reset

  assign rdec            = decode_addr(mem_axi_araddr[31:2], BASE_HI, KEY_WORDS, DATA_WORDS);
  assign mem_axi_arready = rd_live & ~mem_axi_rvalid;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rdec.sel)
      REG_CTRL: begin
        rd_data[CTRL_MODE]   = core_mode;
        rd_data[CTRL_IRQ_EN] = irq_en;
      end
      REG_STATUS: begin
        rd_data[STAT_BUSY]  = busy;
        rd_data[STAT_DONE]  = done;
        rd_data[STAT_ERROR] = error;
      end
      REG_KEY:
        for (int i = 0; i < KEY_WORDS; i++)
          if (rdec.idx == 4'(i)) rd_data = key_q[i];
      REG_DIN:
        for (int i = 0; i < DATA_WORDS; i++)
          if (rdec.idx == 4'(i)) rd_data = din_q[i];
      REG_DOUT:
        for (int i = 0; i < DATA_WORDS; i++)
          if (rdec.idx == 4'(i)) rd_data = dout_q[i];
      default: rd_resp = RESP_DECERR;
    endcase
  end

  // Data is captured at the AR handshake edge, so a read that coincides with
  // a write commit returns the pre-write value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_live        <= 1'b0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= '0;
      mem_axi_rresp  <= RESP_OKAY;
    end else begin
      rd_live <= 1'b1;
      if (mem_axi_arvalid && mem_axi_arready) begin
        mem_axi_rvalid <= 1'b1;
        mem_axi_rdata  <= rd_data;
        mem_axi_rresp  <= rd_resp;
      end else if (mem_axi_rvalid && mem_axi_rready) begin
        mem_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_accel_regbank.sv
module tb_axi4_accel_regbank;

  localparam logic [31:0] BASE = 32'h2500_0000;
  localparam int KW = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_axi_awvalid = 1'b0, mem_axi_awready;
  logic [31:0]   mem_axi_awaddr = '0;
  logic          mem_axi_wvalid = 1'b0, mem_axi_wready;
  logic [31:0]   mem_axi_wdata = '0;
  logic [3:0]    mem_axi_wstrb = '0;
  logic          mem_axi_bvalid, mem_axi_bready = 1'b0;
  logic [1:0]    mem_axi_bresp;
  logic          mem_axi_arvalid = 1'b0, mem_axi_arready;
  logic [31:0]   mem_axi_araddr = '0;
  logic          mem_axi_rvalid, mem_axi_rready = 1'b0;
  logic [31:0]   mem_axi_rdata;
  logic [1:0]    mem_axi_rresp;
  logic          core_start, core_mode, irq;
  logic [32*KW-1:0] core_key;
  logic [32*DW-1:0] core_din;
  logic          core_done = 1'b0;
  logic [32*DW-1:0] core_dout = '0;
  logic          core_error = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;

  axi4_accel_regbank #(.BASE_ADDR(BASE), .KEY_WORDS(KW), .DATA_WORDS(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_axi_awvalid (mem_axi_awvalid),
    .mem_axi_awready (mem_axi_awready),
    .mem_axi_awaddr  (mem_axi_awaddr),
    .mem_axi_wvalid  (mem_axi_wvalid),
    .mem_axi_wready  (mem_axi_wready),
    .mem_axi_wdata   (mem_axi_wdata),
    .mem_axi_wstrb   (mem_axi_wstrb),
    .mem_axi_bvalid  (mem_axi_bvalid),
    .mem_axi_bready  (mem_axi_bready),
    .mem_axi_bresp   (mem_axi_bresp),
    .mem_axi_arvalid (mem_axi_arvalid),
    .mem_axi_arready (mem_axi_arready),
    .mem_axi_araddr  (mem_axi_araddr),
    .mem_axi_rvalid  (mem_axi_rvalid),
    .mem_axi_rready  (mem_axi_rready),
    .mem_axi_rdata   (mem_axi_rdata),
    .mem_axi_rresp   (mem_axi_rresp),
    .core_start      (core_start),
    .core_mode       (core_mode),
    .core_key        (core_key),
    .core_din        (core_din),
    .core_done       (core_done),
    .core_dout       (core_dout),
    .core_error      (core_error),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  // Number of cycles core_start was high.
  always @(posedge clk) if (core_start) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- AXI tasks
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead,
                           output logic [1:0] resp);
    int t_aw = 0, t_w = 0, t_b = 0;
    fork
      begin
        @(negedge clk);
        mem_axi_wvalid = 1'b1; mem_axi_wdata = data; mem_axi_wstrb = strb;
        while (!mem_axi_wready && t_w < 50) begin @(negedge clk); t_w++; end
        @(posedge clk); #1 mem_axi_wvalid = 1'b0;
      end
      begin
        @(negedge clk);
        repeat (w_lead) @(negedge clk);
        mem_axi_awvalid = 1'b1; mem_axi_awaddr = addr;
        while (!mem_axi_awready && t_aw < 50) begin @(negedge clk); t_aw++; end
        @(posedge clk); #1 mem_axi_awvalid = 1'b0;
      end
    join
    while (!mem_axi_bvalid && t_b < 50) begin @(negedge clk); t_b++; end
    resp = mem_axi_bresp;
    if (t_aw >= 50 || t_w >= 50 || t_b >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout addr=%h aw=%0d w=%0d b=%0d", addr, t_aw, t_w, t_b);
    end
    mem_axi_bready = 1'b1;
    @(posedge clk); #1 mem_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int t_ar = 0, t_r = 0;
    @(negedge clk);
    mem_axi_arvalid = 1'b1; mem_axi_araddr = addr;
    while (!mem_axi_arready && t_ar < 50) begin @(negedge clk); t_ar++; end
    @(posedge clk); #1 mem_axi_arvalid = 1'b0;
    while (!mem_axi_rvalid && t_r < 50) begin @(negedge clk); t_r++; end
    data = mem_axi_rdata; resp = mem_axi_rresp;
    if (t_ar >= 50 || t_r >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL read_timeout addr=%h ar=%0d r=%0d", addr, t_ar, t_r);
    end
    mem_axi_rready = 1'b1;
    @(posedge clk); #1 mem_axi_rready = 1'b0;
  endtask

  task automatic pulse_done(input logic [32*DW-1:0] dout, input logic err);
    @(negedge clk);
    core_done = 1'b1; core_dout = dout; core_error = err;
    @(negedge clk);
    core_done = 1'b0; core_error = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    logic [31:0] d; logic [1:0] r;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready,
         mem_axi_rvalid, core_start, irq} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_handshake: got %b expected 0000000",
               {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready,
                mem_axi_rvalid, core_start, irq});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b00) begin
      n_err++; $display("FAIL reset_status: got %h/%b expected 00000000/00", d, r);
    end
    axi_read(BASE + 32'h100, d, r);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b11) begin
      n_err++; $display("FAIL read_out_of_window: got %h/%b expected 00000000/11", d, r);
    end
  endtask

  task automatic test_key_strobe;
    logic [31:0] d; logic [1:0] r;
    axi_write(BASE + 32'h40, 32'h2B7E1516, 4'b0011, 3, r);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL key_lo_bresp: got %b expected 00", r); end
    axi_read(BASE + 32'h40, d, r);
    n_cmp++;
    if (d !== 32'h0000_1516 || r !== 2'b00) begin
      n_err++; $display("FAIL key_lo_read: got %h/%b expected 00001516/00", d, r);
    end
    axi_write(BASE + 32'h40, 32'h2B7E1516, 4'b1100, 3, r);
    n_cmp++;
    if (r !== 2'b00) begin n_err++; $display("FAIL key_hi_bresp: got %b expected 00", r); end
    axi_read(BASE + 32'h40, d, r);
    n_cmp++;
    if (d !== 32'h2B7E1516 || r !== 2'b00) begin
      n_err++; $display("FAIL key_full_read: got %h/%b expected 2b7e1516/00", d, r);
    end
    n_cmp++;
    if (core_key[32*KW-1 -: 32] !== 32'h2B7E1516) begin
      n_err++; $display("FAIL core_key_msb: got %h expected 2b7e1516", core_key[32*KW-1 -: 32]);
    end
  endtask

  task automatic test_decode_errors;
    logic [31:0] d; logic [1:0] r;
    axi_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, 0, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL status_write_resp: got %b expected 10", r); end
    axi_write(BASE + 32'h60, 32'h1234_5678, 4'hF, 0, r);  // KEY[8] not mapped
    n_cmp++;
    if (r !== 2'b11) begin n_err++; $display("FAIL key8_write_resp: got %b expected 11", r); end
    axi_read(BASE + 32'h90, d, r);                          // DIN[4] not mapped
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b11) begin
      n_err++; $display("FAIL din4_read: got %h/%b expected 00000000/11", d, r);
    end
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h0 || r !== 2'b00) begin
      n_err++; $display("FAIL status_after_ro_write: got %h/%b expected 00000000/00", d, r);
    end
  endtask

  task automatic test_start_done;
    logic [31:0] d; logic [1:0] r; int s0;
    s0 = start_cnt;
    axi_write(BASE + 32'h00, 32'h1, 4'hF, 0, r);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (r !== 2'b00 || start_cnt - s0 !== 1) begin
      n_err++; $display("FAIL start_pulse: got resp %b pulses %0d expected 00/1", r, start_cnt - s0);
    end
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL status_busy: got %h expected 00000001", d); end
    pulse_done({32'h3925841D, 32'h11111111, 32'h22222222, 32'h33333333}, 1'b0);
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h2) begin n_err++; $display("FAIL status_done: got %h expected 00000002", d); end
    axi_read(BASE + 32'hC0, d, r);
    n_cmp++;
    if (d !== 32'h3925841D || r !== 2'b00) begin
      n_err++; $display("FAIL dout0_read: got %h/%b expected 3925841d/00", d, r);
    end
    axi_read(BASE + 32'hCC, d, r);
    n_cmp++;
    if (d !== 32'h33333333) begin n_err++; $display("FAIL dout3_read: got %h expected 33333333", d); end
  endtask

  task automatic test_busy_reject;
    logic [31:0] d; logic [1:0] r; int s0;
    axi_write(BASE + 32'h80, 32'hA5A5A5A5, 4'hF, 0, r);
    axi_write(BASE + 32'h00, 32'h3, 4'hF, 0, r);            // start, MODE=1
    n_cmp++;
    if (r !== 2'b00 || core_mode !== 1'b1) begin
      n_err++; $display("FAIL start_mode1: got resp %b mode %b expected 00/1", r, core_mode);
    end
    s0 = start_cnt;
    axi_write(BASE + 32'h80, 32'hDEADBEEF, 4'hF, 0, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL din_busy_resp: got %b expected 10", r); end
    axi_write(BASE + 32'h00, 32'h3, 4'hF, 0, r);
    n_cmp++;
    if (r !== 2'b10) begin n_err++; $display("FAIL start_busy_resp: got %b expected 10", r); end
    axi_write(BASE + 32'h00, 32'h0, 4'hF, 0, r);            // MODE change while busy
    n_cmp++;
    if (r !== 2'b10 || core_mode !== 1'b1) begin
      n_err++; $display("FAIL mode_busy: got resp %b mode %b expected 10/1", r, core_mode);
    end
    axi_read(BASE + 32'h80, d, r);
    n_cmp++;
    if (d !== 32'hA5A5A5A5 || core_din[32*DW-1 -: 32] !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL din_unchanged: got %h/%h expected a5a5a5a5", d, core_din[32*DW-1 -: 32]);
    end
    axi_read(BASE + 32'hC0, d, r);
    n_cmp++;
    if (d !== 32'h3925841D || r !== 2'b00) begin
      n_err++; $display("FAIL dout_while_busy: got %h/%b expected 3925841d/00", d, r);
    end
    n_cmp++;
    if (start_cnt !== s0) begin
      n_err++; $display("FAIL no_second_start: got %0d pulses expected 0", start_cnt - s0);
    end
    pulse_done({32'h0BADF00D, 96'h0}, 1'b1);
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h6) begin n_err++; $display("FAIL status_error: got %h expected 00000006", d); end
  endtask

  task automatic test_irq_clear;
    logic [31:0] d; logic [1:0] r; int t = 0;
    axi_write(BASE + 32'h00, 32'h5, 4'hF, 0, r);            // start, IRQ_EN, MODE=0
    pulse_done({32'hCAFEF00D, 96'h0}, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b expected 1", irq); end
    axi_write(BASE + 32'h00, 32'h5, 4'hF, 0, r);            // restart clears DONE
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_restart: got %b expected 0", irq); end
    // CLR_DONE commit in the same cycle as core_done.
    @(negedge clk);
    mem_axi_awvalid = 1'b1; mem_axi_awaddr = BASE; mem_axi_wvalid = 1'b1;
    mem_axi_wdata = 32'hC; mem_axi_wstrb = 4'hF;
    @(posedge clk); #1;
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0; core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    while (!mem_axi_bvalid && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (mem_axi_bvalid !== 1'b1 || mem_axi_bresp !== 2'b00) begin
      n_err++; $display("FAIL clr_race_bresp: got %b/%b expected 1/00", mem_axi_bvalid, mem_axi_bresp);
    end
    mem_axi_bready = 1'b1;
    @(posedge clk); #1 mem_axi_bready = 1'b0;
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      n_err++; $display("FAIL clr_race_done: got status %h irq %b expected 00000002/1", d, irq);
    end
    axi_write(BASE + 32'h00, 32'hC, 4'hF, 0, r);
    repeat (2) @(negedge clk);
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      n_err++; $display("FAIL clr_alone: got status %h irq %b expected 00000000/0", d, irq);
    end
  endtask

  task automatic test_read_hold;
    int t = 0;
    @(negedge clk);
    mem_axi_arvalid = 1'b1; mem_axi_araddr = BASE + 32'h40;
    while (!mem_axi_arready && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1 mem_axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_axi_rvalid !== 1'b1 || mem_axi_rdata !== 32'h2B7E1516 || mem_axi_rresp !== 2'b00) begin
        n_err++;
        $display("FAIL rready_hold cycle %0d: got %b/%h/%b expected 1/2b7e1516/00",
                 i, mem_axi_rvalid, mem_axi_rdata, mem_axi_rresp);
      end
    end
    mem_axi_rready = 1'b1;
    @(posedge clk); #1 mem_axi_rready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_axi_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rvalid_drop: got %b expected 0", mem_axi_rvalid);
    end
  endtask

  task automatic test_reset_midop;
    logic [31:0] d; logic [1:0] r; int t = 0; int s0;
    axi_write(BASE + 32'h00, 32'h3, 4'hF, 0, r);            // busy, MODE=1
    @(negedge clk);
    mem_axi_awvalid = 1'b1; mem_axi_awaddr = BASE + 32'h44; mem_axi_wvalid = 1'b1;
    mem_axi_wdata = 32'h0F0F0F0F; mem_axi_wstrb = 4'hF;
    @(posedge clk); #1;
    mem_axi_awvalid = 1'b0; mem_axi_wvalid = 1'b0;
    while (!mem_axi_bvalid && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (mem_axi_bvalid !== 1'b1 || mem_axi_bresp !== 2'b10) begin
      n_err++; $display("FAIL pending_b: got %b/%b expected 1/10", mem_axi_bvalid, mem_axi_bresp);
    end
    s0 = start_cnt;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid,
         core_start, irq, core_mode} !== 8'b0 || mem_axi_bresp !== 2'b00 ||
        mem_axi_rresp !== 2'b00 || mem_axi_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_midop_ctl: got %b bresp %b rresp %b rdata %h expected 00000000/00/00/0",
               {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid,
                core_start, irq, core_mode}, mem_axi_bresp, mem_axi_rresp, mem_axi_rdata);
    end
    n_cmp++;
    if (core_key !== '0 || core_din !== '0) begin
      n_err++; $display("FAIL reset_midop_data: got key %h din %h expected 0", core_key, core_din);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    axi_read(BASE + 32'h04, d, r);
    n_cmp++;
    if (d !== 32'h0 || start_cnt !== s0) begin
      n_err++; $display("FAIL post_reset_status: got %h pulses %0d expected 00000000/0", d, start_cnt - s0);
    end
    axi_read(BASE + 32'h40, d, r);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_key: got %h expected 00000000", d); end
  endtask

  initial begin
    test_reset();
    test_key_strobe();
    test_decode_errors();
    test_start_done();
    test_busy_reject();
    test_irq_clear();
    test_read_hold();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
